// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared types and constants for the ADC SPI configuration master.
//   - FSM state enum for the transaction sequencer
//   - Avalon register addresses and widths
//   - SPI frame geometry and STATUS bit positions
package adc_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] REG_INSTR  = 3'd0;
    localparam logic [ADDR_W-1:0] REG_WDATA  = 3'd1;
    localparam logic [ADDR_W-1:0] REG_CTRL   = 3'd2;
    localparam logic [ADDR_W-1:0] REG_STATUS = 3'd3;
    localparam logic [ADDR_W-1:0] REG_RDATA  = 3'd4;

    localparam int unsigned FRAME_BITS = 24;
    localparam int unsigned INSTR_BITS = 16;

    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

endpackage

// File: rtl/adc_spi_if.sv
// adc_spi_if: Avalon-MM slave bus of the ADC SPI configuration block.
//   address   : register select
//   read      : read strobe
//   write     : write strobe
//   writedata : write data
//   readdata  : registered read data (valid the cycle after read)
interface adc_spi_if;
    import adc_spi_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;

    modport master (output address, output read, output write, output writedata, input readdata);
    modport slave  (input address, input read, input write, input writedata, output readdata);

endinterface

// File: rtl/adc_spi_shifter.sv
// adc_spi_shifter: SCLK divider and 24-bit SDIO shift/capture engine.
//   main_clk, rst : clock and synchronous active-high reset
//   load          : latch frame and rw, rewind counters
//   run           : shifting enabled (sequencer is in SHIFT)
//   frame, rw     : frame to send MSB first; rw=1 turns bits 16-23 around
//   sdio_in       : sampled SDIO
//   sclk, sdio_out, sdio_oe : SPI pin values (all low while not running)
//   rdata         : byte captured during the data phase of a read
//   shift_done    : last cycle of bit 23's high half
module adc_spi_shifter
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic                  main_clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  run,
    input  logic [FRAME_BITS-1:0] frame,
    input  logic                  rw,
    input  logic                  sdio_in,
    output logic                  sclk,
    output logic                  sdio_out,
    output logic                  sdio_oe,
    output logic [7:0]            rdata,
    output logic                  shift_done
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);
    localparam logic [4:0] DATA_BIT = 5'(INSTR_BITS);

    logic [DW-1:0]         div_q;
    logic                  high_q;
    logic [4:0]            bit_q;
    logic [FRAME_BITS-1:0] sh_q;
    logic                  rw_q;
    logic                  half_end;

    assign half_end = run && (div_q == DIV_LAST);

    always_ff @(posedge main_clk) begin
        if (rst) begin
            div_q  <= '0;
            high_q <= 1'b0;
            bit_q  <= '0;
            sh_q   <= '0;
            rw_q   <= 1'b0;
            rdata  <= '0;
        end else if (load) begin
            div_q  <= '0;
            high_q <= 1'b0;
            bit_q  <= '0;
            sh_q   <= frame;
            rw_q   <= rw;
        end else if (run) begin
            if (half_end) begin
                div_q  <= '0;
                high_q <= ~high_q;
                // End of a high half: advance to the next bit so the new MSB
                // appears on SDIO at the start of the following low half.
                if (high_q) begin
                    sh_q  <= {sh_q[FRAME_BITS-2:0], 1'b0};
                    bit_q <= bit_q + 5'd1;
                    if (rw_q && bit_q >= DATA_BIT)
                        rdata <= {rdata[6:0], sdio_in};
                end
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign sclk       = run & high_q;
    assign sdio_out   = run & sh_q[FRAME_BITS-1];
    assign sdio_oe    = run & ((bit_q < DATA_BIT) | ~rw_q);
    assign shift_done = half_end & high_q & (bit_q == LAST_BIT);

endmodule

// File: rtl/adc_spi_config.sv
// adc_spi_config: Avalon-MM controlled 3-wire SPI master for ADC register access.
//   main_clk, rst  : sole clock, synchronous active-high reset
//   avs            : Avalon-MM slave (INSTR, WDATA, CTRL, STATUS, RDATA)
//   adc_csb_n      : chip select, active low
//   adc_sclk       : SPI clock, idles low
//   adc_sdio_out/oe: SDIO drive value and enable (tristate built above)
//   adc_sdio_in    : SDIO sampled value
//   busy           : transaction in progress
module adc_spi_config
    import adc_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic        main_clk,
    input  logic        rst,
    adc_spi_if.slave    avs,
    output logic        adc_csb_n,
    output logic        adc_sclk,
    output logic        adc_sdio_out,
    output logic        adc_sdio_oe,
    input  logic        adc_sdio_in,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] instr_q;
    logic [7:0]  wdata_q;
    logic        done_q, err_q;
    logic [7:0]  rdata;
    logic        start_req, wr_status;
    logic        shift_load, shift_run, shift_done, set_done;
    logic [15:0] status, rd_mux;

    assign start_req = avs.write && (avs.address == REG_CTRL) && avs.writedata[0];
    assign wr_status = avs.write && (avs.address == REG_STATUS);
    assign shift_run = (state_q == ST_SHIFT);
    assign busy      = (state_q != ST_IDLE);
    assign adc_csb_n = !((state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_load = 1'b0;
        set_done   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d    = ST_SETUP;
                    cnt_d      = '0;
                    shift_load = 1'b1;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 8'(CS_SETUP - 1)) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 8'(CS_HOLD - 1)) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == 8'(CS_GAP - 1)) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    set_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy;
        status[STAT_DONE] = done_q;
        status[STAT_ERR]  = err_q;
        case (avs.address)
            REG_INSTR:  rd_mux = instr_q;
            REG_WDATA:  rd_mux = {8'h00, wdata_q};
            REG_STATUS: rd_mux = status;
            REG_RDATA:  rd_mux = {8'h00, rdata};
            default:    rd_mux = '0;
        endcase
    end

    always_ff @(posedge main_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            instr_q      <= '0;
            wdata_q      <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            avs.readdata <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (avs.write && avs.address == REG_INSTR)
                instr_q <= avs.writedata;
            if (avs.write && avs.address == REG_WDATA)
                wdata_q <= avs.writedata[7:0];
            // Completion set outranks a simultaneous software clear.
            done_q <= set_done | (done_q & ~(wr_status & avs.writedata[STAT_DONE]));
            err_q  <= (start_req & busy) | (err_q & ~(wr_status & avs.writedata[STAT_ERR]));
            avs.readdata <= avs.read ? rd_mux : '0;
        end
    end

    adc_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .main_clk   (main_clk),
        .rst        (rst),
        .load       (shift_load),
        .run        (shift_run),
        .frame      ({instr_q[15], 2'b00, instr_q[12:0], wdata_q}),
        .rw         (instr_q[15]),
        .sdio_in    (adc_sdio_in),
        .sclk       (adc_sclk),
        .sdio_out   (adc_sdio_out),
        .sdio_oe    (adc_sdio_oe),
        .rdata      (rdata),
        .shift_done (shift_done)
    );

endmodule
